// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell reused LSB-first over WIDTH cycles, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
  ,output logic            ovf_o
`endif
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic             creg_q, creg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a_i (areg_q[0]),
    .b_i (breg_q[0]),
    .c_i (creg_q),
    .s_o (fa_s),
    .co_o(fa_co)
  );

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    creg_d  = creg_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          areg_d  = a_i;
          breg_d  = b_i;
          creg_d  = cin_i;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sum_d  = {fa_s, sum_q[WIDTH-1:1]};
        creg_d = fa_co;
        areg_d = areg_q >> 1;
        breg_d = breg_q >> 1;
        if (cnt_q == LAST) begin
          // creg_q here is the carry into the MSB, fa_co the carry out of it
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = creg_q ^ fa_co;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      creg_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      creg_q  <= creg_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf_o  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl; expected results come from plain a+b+cin arithmetic.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .cin_i  (cin),
    .busy_o (busy),
    .done_o (done),
    .sum_o  (sum),
    .cout_o (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,.ovf_o (ovf)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned sum of width W+1, signed overflow from operand/result sign bits.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    logic [W:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
`ifdef SERIAL_ADD_OVF_EN
    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`else
    v = 1'b0;
`endif
    return {s, v};
  endfunction

  // Launch one op and follow it until the cycle after done; noise re-pulses start while busy.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input bit noise, input string tag);
    logic [W+1:0] exp;
    exp   = ref_add(xa, xb, xc);
    a     = xa;
    b     = xb;
    cin   = xc;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s shift_phase k=%0d busy=%b done=%b want busy=1 done=0", tag, k, busy, done);
      end
      if (noise && k == 2) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse busy=%b done=%b want busy=1 done=1", tag, busy, done);
    end
    checks++;
    if ({cout, sum, ovf} !== exp) begin
      errors++;
      $display("FAIL %s result got cout=%b sum=%h ovf=%b want cout=%b sum=%h ovf=%b",
               tag, cout, sum, ovf, exp[W+1], exp[W:1], exp[0]);
    end
    if (noise) begin
      start = 1'b1;
      a     = W'($urandom);
      b     = W'($urandom);
    end
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {cout, sum, ovf} !== exp) begin
      errors++;
      $display("FAIL %s after_done busy=%b done=%b cout=%b sum=%h want busy=0 done=0 cout=%b sum=%h",
               tag, busy, done, cout, sum, exp[W+1], exp[W:1]);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h3C;
    b     = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc=%0d busy=%b done=%b sum=%h cout=%b want all zero",
                 i, busy, done, sum, cout);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [W+1:0] exp;
    run_op(8'h3C, 8'h5A, 1'b0, 0, "add_3c_5a");
    exp = ref_add(8'h3C, 8'h5A, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (sum !== 8'h96 || cout !== 1'b0 || done !== 1'b0 || exp[W:1] !== 8'h96) begin
        errors++;
        $display("FAIL hold_3c_5a cyc=%0d sum=%h cout=%b done=%b want sum=96 cout=0 done=0",
                 i, sum, cout, done);
      end
    end
    run_op(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
    run_op(8'h7F, 8'h01, 1'b0, 0, "add_7f_01");
    run_op(8'h80, 8'h80, 1'b0, 0, "add_80_80");
  endtask

  task automatic test_start_while_busy();
    run_op(8'hFF, 8'hFF, 1'b1, 1, "busy_ignore");
  endtask

  task automatic test_reset_mid_op();
    a     = 8'h3C;
    b     = 8'h5A;
    cin   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b sum=%h cout=%b want all zero", busy, done, sum, cout);
    end
    for (int i = 0; i < W + 2; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_quiet cyc=%0d busy=%b done=%b want 0 0", i, busy, done);
      end
    end
    run_op(8'h01, 8'h02, 1'b0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int fails_before;
    fails_before = errors;
    for (int n = 0; n < 1000 && errors - fails_before < 10; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, "random");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
